i2c_init_sequencer: RTL and testbench

//  Upstream command source for the I2C byte master on the HDMI config path.

---
 rtl/i2c_init_sequencer_pkg.sv | 39 +++
 rtl/i2c_init_sequencer_if.sv | 36 +++
 rtl/i2c_init_sequencer_rom.sv | 24 ++
 rtl/i2c_init_sequencer.sv | 132 +++++++++++++
 tb/tb_i2c_init_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_init_sequencer_pkg.sv
// Shared HDMI-config definitions: sequencer states, init-table entry layout, ADV7513 init table.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_init_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    // One table word is {register address, data byte}.
    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } init_entry_t;

    // ADV7513 bring-up: power up TX, fixed 0x98/0x9A/0x9C/0x9D/0xA2/0xA3/0xE0 values, in that order.
    localparam int INIT_LEN = 8;
    localparam logic [15:0] INIT_TABLE [INIT_LEN] = '{
        16'h4110,
        16'h9803,
        16'h9AE0,
        16'h9C30,
        16'h9D61,
        16'hA2A4,
        16'hA3A4,
        16'hE0D0
    };

    // Width needed to hold the values 0..n-1 (never less than one bit).
    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// Command/response bus between the init sequencer and the I2C byte master.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; xfer_done/xfer_nack are unthrottled pulses.
interface i2c_init_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       xfer_done;
    logic       xfer_nack;

    // Sequencer side: offers commands, receives transfer results.
    modport master (
        output cmd_valid,
        output cmd_dev_addr,
        output cmd_reg,
        output cmd_data,
        input  cmd_ready,
        input  xfer_done,
        input  xfer_nack
    );

    // I2C byte master side.
    modport slave (
        input  cmd_valid,
        input  cmd_dev_addr,
        input  cmd_reg,
        input  cmd_data,
        output cmd_ready,
        output xfer_done,
        output xfer_nack
    );

endinterface

// File: rtl/i2c_init_sequencer_rom.sv
// Init-table lookup: entry index -> {reg, data}; indices past the table return zero.
// Latency: combinational.
// Backpressure: none.
module i2c_init_rom
    import i2c_init_sequencer_pkg::*;
#(
    parameter int NUM_ENTRIES = INIT_LEN,
    parameter int IDX_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic [IDX_W-1:0] idx,
    output init_entry_t      entry
);

    // Constant-indexed compare chain keeps the table index width independent of IDX_W.
    always_comb begin
        entry = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (idx == IDX_W'(i)) begin
                entry = init_entry_t'(INIT_TABLE[i]);
            end
        end
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init table after a power-up delay, issuing one 3-byte register write per entry with retry.
// Latency: first cmd_valid POWERUP_CYCLES+1 cycles after reset release; GAP_CYCLES idle between commands.
// Backpressure: command fields held stable while cmd_valid && !cmd_ready; results only accepted in WAIT.
module i2c_init_sequencer
    import i2c_init_sequencer_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = 7'h39,
    parameter int         NUM_ENTRIES    = INIT_LEN,
    parameter int         POWERUP_CYCLES = 25000,
    parameter int         GAP_CYCLES     = 16,
    parameter int         MAX_RETRY      = 3,
    parameter int         TIMEOUT_CYCLES = 65535,
    localparam int        IDX_W          = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    i2c_init_sequencer_if.master bus,
    output logic [IDX_W-1:0]     entry_idx,
    output logic                 init_done,
    output logic                 init_error
);

    // One elapsed-cycle counter is shared by POWERUP, GAP and WAIT since only one is ever active.
    localparam int CNT_SPAN_A = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
    localparam int CNT_SPAN   = (CNT_SPAN_A > TIMEOUT_CYCLES) ? CNT_SPAN_A : TIMEOUT_CYCLES;
    localparam int CNT_W      = bits_for(CNT_SPAN);
    localparam int RETRY_W    = bits_for(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   PU_LAST   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    init_entry_t          rom_entry;

    logic handshake;
    logic wait_ack;
    logic wait_fail;
    logic can_retry;
    logic last_entry;
    logic restart_ok;
    logic counting;

    i2c_init_rom #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_rom (
        .idx   (entry_idx),
        .entry (rom_entry)
    );

    // A result pulse only counts in WAIT; an ACK wins over a timeout landing in the same cycle.
    assign handshake  = (state_q == ST_ISSUE) && bus.cmd_ready;
    assign wait_ack   = (state_q == ST_WAIT) && bus.xfer_done && !bus.xfer_nack;
    assign wait_fail  = (state_q == ST_WAIT) && !wait_ack &&
                        ((bus.xfer_done && bus.xfer_nack) || (cnt == TO_LAST));
    assign can_retry  = (retry_cnt < RETRY_MAX);
    assign last_entry = (entry_idx == IDX_LAST);
    assign restart_ok = restart && ((state_q == ST_DONE) || (state_q == ST_ERROR));
    assign counting   = (state_q == ST_POWERUP) || (state_q == ST_GAP) || (state_q == ST_WAIT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_POWERUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_POWERUP: if (cnt == PU_LAST) state_d = ST_ISSUE;
            ST_ISSUE:   if (handshake) state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_ack) begin
                    state_d = last_entry ? ST_DONE : ST_GAP;
                end else if (wait_fail) begin
                    state_d = can_retry ? ST_GAP : ST_ERROR;
                end
            end
            ST_GAP:     if (cnt == GAP_LAST) state_d = ST_ISSUE;
            ST_DONE:    if (restart) state_d = ST_GAP;
            ST_ERROR:   if (restart) state_d = ST_GAP;
            default:    state_d = ST_POWERUP;
        endcase
    end

    // Counter restarts on every state change; entry index and retry count follow transfer results.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            entry_idx <= '0;
            retry_cnt <= '0;
        end else begin
            if (state_d != state_q) begin
                cnt <= '0;
            end else if (counting) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (wait_ack) begin
                entry_idx <= entry_idx + IDX_W'(1);
                retry_cnt <= '0;
            end else if (wait_fail && can_retry) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end else if (restart_ok) begin
                entry_idx <= '0;
                retry_cnt <= '0;
            end
        end
    end

    // Outputs decode from the registered state; fields come straight from the table so they hold with the index.
    always_comb begin
        bus.cmd_valid    = (state_q == ST_ISSUE);
        bus.cmd_dev_addr = DEV_ADDR;
        bus.cmd_reg      = rom_entry.reg_addr;
        bus.cmd_data     = rom_entry.data;
        init_done        = (state_q == ST_DONE);
        init_error       = (state_q == ST_ERROR);
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer with a behavioural I2C master (fixed 3-cycle response).
// Latency: n/a.
// Backpressure: cmd_ready driven directly by the directed sequence.
module tb_i2c_init_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic [1:0] entry_idx;
    logic       init_done;
    logic       init_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Handshake log and master-model controls.
    logic [7:0] hs_reg  [64];
    logic [7:0] hs_data [64];
    logic [6:0] hs_dev  [64];
    int         hs_cyc  [64];
    int         hs_n = 0;
    int         pend = 0;
    logic       pend_nack = 1'b0;
    int         nack_given = 0;
    logic [7:0] nack_reg = 8'h00;
    int         nack_base = 0;
    int         nack_quota = 0;
    bit         no_resp = 1'b0;

    i2c_init_sequencer_if bus();

    i2c_init_sequencer #(
        .DEV_ADDR       (7'h39),
        .NUM_ENTRIES    (3),
        .POWERUP_CYCLES (10),
        .GAP_CYCLES     (4),
        .MAX_RETRY      (2),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .bus        (bus),
        .entry_idx  (entry_idx),
        .init_done  (init_done),
        .init_error (init_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Master model: logs handshakes at the negedge, drives xfer_done/xfer_nack 2ns after posedge.
    initial begin
        bus.xfer_done = 1'b0;
        bus.xfer_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
                if (hs_n < 64) begin
                    hs_reg[hs_n]  = bus.cmd_reg;
                    hs_data[hs_n] = bus.cmd_data;
                    hs_dev[hs_n]  = bus.cmd_dev_addr;
                    hs_cyc[hs_n]  = cyc;
                end
                hs_n++;
                if (!no_resp) begin
                    pend      = 3;
                    pend_nack = (bus.cmd_reg == nack_reg) && ((nack_given - nack_base) < nack_quota);
                    if (pend_nack) nack_given++;
                end
            end
            @(posedge clk);
            #2;
            bus.xfer_done = 1'b0;
            bus.xfer_nack = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.xfer_done = 1'b1;
                    bus.xfer_nack = pend_nack;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_restart();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // Counts edges after reset release until cmd_valid is seen (bounded).
    task automatic wait_first_valid(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.cmd_valid === 1'b1) break;
        end
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done === 1'b1 || init_error === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int b;
        bit ok;

        bus.cmd_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        chk("rst_valid", bus.cmd_valid, 1'b0);
        chk("rst_idx", entry_idx, 2'd0);
        chk("rst_done", init_done, 1'b0);
        chk("rst_err", init_error, 1'b0);
        chk("rst_reg", bus.cmd_reg, 8'h41);
        chk("rst_data", bus.cmd_data, 8'h10);
        chk("rst_dev", bus.cmd_dev_addr, 7'h39);
        reset = 1'b0;

        // 1: all ACK, ready tied high.
        wait_first_valid(n);
        chk("t1_first_valid_cycle", n + 1, 11);
        wait_end(400, ok);
        chk("t1_end_reached", ok, 1'b1);
        chk("t1_hs_count", hs_n, 3);
        chk("t1_reg0", hs_reg[0], 8'h41);
        chk("t1_data0", hs_data[0], 8'h10);
        chk("t1_reg1", hs_reg[1], 8'h98);
        chk("t1_data1", hs_data[1], 8'h03);
        chk("t1_reg2", hs_reg[2], 8'h9A);
        chk("t1_data2", hs_data[2], 8'hE0);
        chk("t1_dev0", hs_dev[0], 7'h39);
        chk("t1_dev2", hs_dev[2], 7'h39);
        chk("t1_done", init_done, 1'b1);
        chk("t1_err", init_error, 1'b0);
        chk("t1_idx", entry_idx, 2'd3);

        // 2: backpressure on entry 0 for 7 cycles.
        tick();
        bus.cmd_ready = 1'b0;
        b = hs_n;
        pulse_restart();
        wait_first_valid(n);
        chk("t2_valid_seen", bus.cmd_valid, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("t2_hold_valid", bus.cmd_valid, 1'b1);
            chk("t2_hold_reg", bus.cmd_reg, 8'h41);
            chk("t2_hold_data", bus.cmd_data, 8'h10);
            @(negedge clk);
        end
        tick();
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        repeat (20) tick();
        chk("t2_one_hs", hs_n - b, 1);
        chk("t2_hs_reg", hs_reg[b], 8'h41);
        chk("t2_idx_next", entry_idx, 2'd1);
        chk("t2_next_offered", bus.cmd_valid, 1'b1);
        chk("t2_next_reg", bus.cmd_reg, 8'h98);
        bus.cmd_ready = 1'b1;
        wait_end(400, ok);
        chk("t2_done", init_done, 1'b1);

        // 3: entry 1 NACKs twice then ACKs.
        tick();
        nack_reg   = 8'h98;
        nack_base  = nack_given;
        nack_quota = 2;
        b = hs_n;
        pulse_restart();
        wait_end(400, ok);
        chk("t3_end_reached", ok, 1'b1);
        chk("t3_hs_count", hs_n - b, 5);
        chk("t3_att1_reg", hs_reg[b + 1], 8'h98);
        chk("t3_att2_reg", hs_reg[b + 2], 8'h98);
        chk("t3_att3_reg", hs_reg[b + 3], 8'h98);
        chk("t3_retry_spacing1", hs_cyc[b + 2] - hs_cyc[b + 1], 8);
        chk("t3_retry_spacing2", hs_cyc[b + 3] - hs_cyc[b + 2], 8);
        chk("t3_last_reg", hs_reg[b + 4], 8'h9A);
        chk("t3_done", init_done, 1'b1);
        chk("t3_err", init_error, 1'b0);
        chk("t3_idx", entry_idx, 2'd3);

        // 4: entry 2 always NACKs, then restart reruns cleanly.
        tick();
        nack_reg   = 8'h9A;
        nack_base  = nack_given;
        nack_quota = 1000;
        b = hs_n;
        pulse_restart();
        wait_end(400, ok);
        chk("t4_end_reached", ok, 1'b1);
        chk("t4_hs_count", hs_n - b, 5);
        chk("t4_err", init_error, 1'b1);
        chk("t4_done", init_done, 1'b0);
        chk("t4_idx", entry_idx, 2'd2);
        chk("t4_valid_idle", bus.cmd_valid, 1'b0);
        tick();
        nack_quota = 0;
        b = hs_n;
        pulse_restart();
        chk("t4_restart_idx", entry_idx, 2'd0);
        chk("t4_restart_err_clr", init_error, 1'b0);
        wait_end(400, ok);
        chk("t4_rerun_done", init_done, 1'b1);
        chk("t4_rerun_hs", hs_n - b, 3);
        chk("t4_rerun_first", hs_reg[b], 8'h41);

        // 5: master never answers; each attempt times out.
        tick();
        no_resp = 1'b1;
        b = hs_n;
        pulse_restart();
        wait_end(600, ok);
        chk("t5_end_reached", ok, 1'b1);
        chk("t5_err", init_error, 1'b1);
        chk("t5_hs_count", hs_n - b, 3);
        chk("t5_reg", hs_reg[b + 2], 8'h41);
        chk("t5_timeout_spacing", hs_cyc[b + 1] - hs_cyc[b], 55);
        chk("t5_idx", entry_idx, 2'd0);

        // 6: reset while in WAIT.
        b = hs_n;
        pulse_restart();
        n = 0;
        while (hs_n == b && n < 100) begin
            tick();
            n++;
        end
        chk("t6_in_wait", bus.cmd_valid, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", bus.cmd_valid, 1'b0);
        chk("t6_rst_idx", entry_idx, 2'd0);
        chk("t6_rst_err", init_error, 1'b0);
        chk("t6_rst_done", init_done, 1'b0);
        chk("t6_rst_reg", bus.cmd_reg, 8'h41);
        tick();
        reset = 1'b0;
        no_resp = 1'b0;
        b = hs_n;
        wait_first_valid(n);
        chk("t6_first_valid_cycle", n + 1, 11);
        wait_end(400, ok);
        chk("t6_done", init_done, 1'b1);
        chk("t6_hs_count", hs_n - b, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
